// File: rtl/bram_frame_writer_pkg.sv
// Shared definitions for the BRAM frame writer and its reader counterpart:
// default BRAM geometry and the writer FSM state encoding.
package bram_frame_writer_pkg;

    localparam int BRAM_ADDR_WIDTH = 15;
    localparam int BRAM_DATA_WIDTH = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

endpackage

// File: rtl/bram_frame_writer.sv
// Captures one frame of stream samples into a BRAM write port, one word per
// address from 0, ending on s_tlast or FRAME_LEN words with sticky framing errors.
module bram_frame_writer
    import bram_frame_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = BRAM_DATA_WIDTH,
    parameter int FRAME_LEN  = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tlast,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   frame_words,
    output logic                  err_short,
    output logic                  err_long,
    output logic [1:0]            dbg_state
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] index;
    logic                  accept;
    logic                  final_beat;

    // Handshake: a beat transfers on a clk edge where s_tvalid and s_tready are
    // both high. s_tready is registered and high only in CAPTURE, so the source
    // holds s_tdata/s_tlast steady until such an edge occurs.
    assign accept     = s_tvalid && s_tready;
    assign final_beat = s_tlast || (index == LAST_IDX);
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            index       <= '0;
            s_tready    <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_words <= '0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_CAPTURE;
                        index     <= '0;
                        s_tready  <= 1'b1;
                        busy      <= 1'b1;
                        err_short <= 1'b0;
                        err_long  <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= index;
                        wr_data <= s_tdata;
                        if (final_beat) begin
                            // index stays put here so it never wraps at 2**ADDR_WIDTH
                            state       <= ST_FLUSH;
                            s_tready    <= 1'b0;
                            done        <= 1'b1;
                            frame_words <= {1'b0, index} + (ADDR_WIDTH + 1)'(1);
                            if (s_tlast && (index != LAST_IDX))
                                err_short <= 1'b1;
                            if (!s_tlast && (index == LAST_IDX))
                                err_long <= 1'b1;
                        end else begin
                            index <= index + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    s_tready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_frame_writer.sv
// Directed bench for bram_frame_writer: one FRAME_LEN=8 instance with wide
// addresses and one ADDR_WIDTH=3 instance, driven by the same stream.
module tb_bram_frame_writer;
    import bram_frame_writer_pkg::*;

    localparam int AW  = 15;
    localparam int DW  = 32;
    localparam int FL  = 8;
    localparam int AWB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic [DW-1:0] s_tdata = '0;

    logic          a_s_tready, a_wr_en, a_busy, a_done, a_err_short, a_err_long;
    logic [AW-1:0] a_wr_addr;
    logic [DW-1:0] a_wr_data;
    logic [AW:0]   a_frame_words;
    logic [1:0]    a_dbg_state;

    logic           b_s_tready, b_wr_en, b_busy, b_done, b_err_short, b_err_long;
    logic [AWB-1:0] b_wr_addr;
    logic [DW-1:0]  b_wr_data;
    logic [AWB:0]   b_frame_words;
    logic [1:0]     b_dbg_state;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [AW-1:0]    exp_last_addr = '0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_e;

    bram_frame_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_LEN(FL)) dut_a (
        .clk(clk), .rst(rst), .start(start),
        .s_tvalid(s_tvalid), .s_tready(a_s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .busy(a_busy), .done(a_done), .frame_words(a_frame_words),
        .err_short(a_err_short), .err_long(a_err_long), .dbg_state(a_dbg_state)
    );

    bram_frame_writer #(.ADDR_WIDTH(AWB), .DATA_WIDTH(DW)) dut_b (
        .clk(clk), .rst(rst), .start(start),
        .s_tvalid(s_tvalid), .s_tready(b_s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .busy(b_busy), .done(b_done), .frame_words(b_frame_words),
        .err_short(b_err_short), .err_long(b_err_long), .dbg_state(b_dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every observed write must match the head of exp_q
    always @(negedge clk) begin
        if (!rst) begin
            if (a_wr_en || b_wr_en) begin
                check("wr_pending", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("a_wr_en", 64'(a_wr_en), 64'(1));
                    check("b_wr_en", 64'(b_wr_en), 64'(1));
                    check("a_wr_addr", 64'(a_wr_addr), 64'(mon_e[AW+DW-1:DW]));
                    check("b_wr_addr", 64'(b_wr_addr), 64'(mon_e[AW+DW-1:DW]));
                    check("a_wr_data", 64'(a_wr_data), 64'(mon_e[DW-1:0]));
                    check("b_wr_data", 64'(b_wr_data), 64'(mon_e[DW-1:0]));
                end
            end
            if (a_done || b_done) begin
                done_cnt++;
                check("a_done", 64'(a_done), 64'(1));
                check("b_done", 64'(b_done), 64'(1));
                check("done_wr_en", 64'(a_wr_en), 64'(1));
                check("done_a_addr", 64'(a_wr_addr), 64'(exp_last_addr));
                check("done_b_addr", 64'(b_wr_addr), 64'(exp_last_addr));
                check("done_state", 64'(a_dbg_state), 64'(ST_FLUSH));
            end
        end
    end

    // driver tasks
    task automatic push_writes(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++)
            exp_q.push_back({AW'(i), base + DW'(i)});
        exp_last_addr = AW'(n - 1);
    endtask

    task automatic arm(input logic with_beat, input logic [DW-1:0] d);
        start    = 1'b1;
        s_tvalid = with_beat;
        s_tdata  = d;
        s_tlast  = 1'b0;
        @(negedge clk);
        check("tready_pre_arm", 64'(a_s_tready), 64'(0));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("arm_busy_a", 64'(a_busy), 64'(1));
        check("arm_busy_b", 64'(b_busy), 64'(1));
        check("arm_tready", 64'(a_s_tready), 64'(1));
    endtask

    // Presents n beats (data base+i, s_tlast on beat last_beat, 1-based, 0=none),
    // s_tvalid per cycle from vpat, start re-pulsed on cycle restart_cyc.
    task automatic stream(input int n, input logic [DW-1:0] base, input int last_beat,
                          input logic [15:0] vpat, input int restart_cyc, input int budget,
                          output int acc, output int cyc);
        int   i;
        logic rdy;
        i   = 0;
        acc = 0;
        cyc = 0;
        while (i < n && cyc < budget) begin
            s_tvalid = vpat[cyc % 16];
            s_tdata  = base + DW'(i);
            s_tlast  = (i + 1 == last_beat);
            start    = (cyc == restart_cyc);
            @(negedge clk);
            rdy = a_s_tready;
            @(posedge clk);
            if (s_tvalid && rdy) begin
                acc++;
                i++;
            end
            #1;
            cyc++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        start    = 1'b0;
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tready"}, 64'(a_s_tready), 64'(0));
        check({tag, "_wr_en"}, 64'(a_wr_en), 64'(0));
        check({tag, "_wr_addr"}, 64'(a_wr_addr), 64'(0));
        check({tag, "_wr_data"}, 64'(a_wr_data), 64'(0));
        check({tag, "_busy"}, 64'(a_busy), 64'(0));
        check({tag, "_done"}, 64'(a_done), 64'(0));
        check({tag, "_fw"}, 64'(a_frame_words), 64'(0));
        check({tag, "_es"}, 64'(a_err_short), 64'(0));
        check({tag, "_el"}, 64'(a_err_long), 64'(0));
        check({tag, "_state"}, 64'(a_dbg_state), 64'(ST_IDLE));
        check({tag, "_b_wr_en"}, 64'(b_wr_en), 64'(0));
        check({tag, "_b_busy"}, 64'(b_busy), 64'(0));
        check({tag, "_b_fw"}, 64'(b_frame_words), 64'(0));
        check({tag, "_b_tready"}, 64'(b_s_tready), 64'(0));
    endtask

    task automatic check_frame(input string tag, input int fw, input logic es,
                               input logic el, input int done_before);
        check({tag, "_fw_a"}, 64'(a_frame_words), 64'(fw));
        check({tag, "_fw_b"}, 64'(b_frame_words), 64'(fw));
        check({tag, "_es_a"}, 64'(a_err_short), 64'(es));
        check({tag, "_es_b"}, 64'(b_err_short), 64'(es));
        check({tag, "_el_a"}, 64'(a_err_long), 64'(el));
        check({tag, "_el_b"}, 64'(b_err_long), 64'(el));
        check({tag, "_busy"}, 64'(a_busy), 64'(0));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(done_before + 1));
        check({tag, "_q_left"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int acc, cyc, d0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst0");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // full frame, first beat offered together with start
        d0 = done_cnt;
        push_writes(8, 32'h100);
        arm(1'b1, 32'h100);
        stream(8, 32'h100, 8, 16'hFFFF, -1, 20, acc, cyc);
        check("s1_acc", 64'(acc), 64'(8));
        check("s1_cycles", 64'(cyc), 64'(8));
        idle_wait(2);
        check_frame("s1", 8, 1'b0, 1'b0, d0);
        check("s1_b_fw_bits", 64'(b_frame_words), 64'(4'b1000));

        // short frame, then start during FLUSH must be ignored
        d0 = done_cnt;
        push_writes(5, 32'h300);
        arm(1'b0, '0);
        stream(5, 32'h300, 5, 16'hFFFF, -1, 20, acc, cyc);
        check("s2_acc", 64'(acc), 64'(5));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("s2_flush_start_busy", 64'(a_busy), 64'(0));
        check("s2_flush_start_es", 64'(a_err_short), 64'(1));
        idle_wait(1);
        check_frame("s2", 5, 1'b1, 1'b0, d0);

        // long frame: start clears err_short, beats 9-10 stall
        d0 = done_cnt;
        push_writes(8, 32'h400);
        arm(1'b0, '0);
        check("s3_es_cleared_a", 64'(a_err_short), 64'(0));
        check("s3_es_cleared_b", 64'(b_err_short), 64'(0));
        stream(10, 32'h400, 0, 16'hFFFF, -1, 14, acc, cyc);
        check("s3_acc", 64'(acc), 64'(8));
        check("s3_tready_low", 64'(a_s_tready), 64'(0));
        idle_wait(1);
        check_frame("s3", 8, 1'b0, 1'b1, d0);

        // gapped valid with a start re-pulse mid-capture
        d0 = done_cnt;
        push_writes(8, 32'h500);
        arm(1'b0, '0);
        stream(8, 32'h500, 8, 16'hFF6D, 3, 30, acc, cyc);
        check("s4_acc", 64'(acc), 64'(8));
        check("s4_cycles", 64'(cyc), 64'(11));
        idle_wait(2);
        check_frame("s4", 8, 1'b0, 1'b0, d0);

        // reset after 3 of 8 beats
        d0 = done_cnt;
        push_writes(3, 32'h600);
        arm(1'b0, '0);
        stream(3, 32'h600, 0, 16'hFFFF, -1, 10, acc, cyc);
        check("s5_acc", 64'(acc), 64'(3));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("s5_mid");
        @(posedge clk);
        #1;
        check_reset_outputs("s5_hold");
        rst = 1'b0;
        idle_wait(1);
        check("s5_no_done", 64'(done_cnt), 64'(d0));
        check("s5_q_left", 64'(exp_q.size()), 64'(0));

        // fresh frame after reset writes from address 0
        d0 = done_cnt;
        push_writes(8, 32'h700);
        arm(1'b0, '0);
        stream(8, 32'h700, 8, 16'hFFFF, -1, 20, acc, cyc);
        check("s6_acc", 64'(acc), 64'(8));
        idle_wait(2);
        check_frame("s6", 8, 1'b0, 1'b0, d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
